cyclic_bank_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one cyclic_bank wide memory among NUM_REQ requesters. Each requester issues 1-4 word reads or writes over a valid/ready handshake. The arbiter drives the bank's re/we/len/wordAdr/din. It captures the 1-cycle-latency bank read data into a response register that holds under back-pressure, and tags each response with the requester ID. The block sits between the compute-engine ports and the cyclic_bank instance.

---
 rtl/cyclic_bank_arb_pkg.sv | 14 +
 rtl/cyclic_rr_pick.sv | 28 ++
 rtl/cyclic_bank_arb.sv | 126 ++++++++++++
 tb/tb_cyclic_bank_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cyclic_bank_arb_pkg.sv
// Shared types and helpers for the cyclic_bank round-robin arbiter.
package cyclic_bank_arb_pkg;

    localparam int LINE_WORDS  = 4;
    localparam int LINE_DATA_W = 32;

    typedef logic [1:0] len_t;
    typedef logic [LINE_WORDS-1:0][LINE_DATA_W-1:0] line_t;

    function automatic logic [2:0] len_words(len_t len);
        return {1'b0, len} + 3'd1;
    endfunction

endpackage

// File: rtl/cyclic_rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
module cyclic_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any_grant
);

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (int'(ptr) + k) % NUM_REQ;
            if (!any_grant && elig[c]) begin
                any_grant = 1'b1;
                grant[c]  = 1'b1;
                idx       = ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/cyclic_bank_arb.sv
// Round-robin arbiter sharing one cyclic_bank among NUM_REQ requesters.
// Optional grant locking is enabled by defining CYCLIC_BANK_ARB_LOCK_EN.
module cyclic_bank_arb
    import cyclic_bank_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic [NUM_REQ-1:0]                      req_we,
    input  logic [NUM_REQ*2-1:0]                    req_len,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]           req_adr,
    input  logic [NUM_REQ*LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
`ifdef CYCLIC_BANK_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]                      req_lock,
`endif
    output logic                                    rsp_valid,
    input  logic                                    rsp_ready,
    output logic [ID_W-1:0]                         rsp_id,
    output logic [LINE_WORDS*DATA_WIDTH-1:0]        rsp_data,
    output logic                                    bank_re,
    output logic                                    bank_we,
    output logic [1:0]                              bank_len,
    output logic [ADDR_WIDTH-1:0]                   bank_adr,
    output logic [LINE_WORDS*DATA_WIDTH-1:0]        bank_din,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0]        bank_dout
);

    localparam int LW = LINE_WORDS * DATA_WIDTH;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    next_ptr;
    logic [ID_W-1:0]    g_idx;
    logic [ID_W-1:0]    rd_id_p1;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic               any_grant;
    logic               rd_inflight;
    logic               rd_ok;
    len_t               g_len;

    // A read may only issue when its response slot is guaranteed free at capture.
    assign rd_ok = !rd_inflight && (!rsp_valid || rsp_ready);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (req_we[i] || rd_ok);
        end
    end

    cyclic_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .elig      (elig),
        .ptr       (rr_ptr),
        .grant     (grant),
        .idx       (g_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        req_ready = '0;
        bank_re   = 1'b0;
        bank_we   = 1'b0;
        g_len     = '0;
        bank_adr  = '0;
        bank_din  = '0;
        if (any_grant) begin
            req_ready = grant;
            bank_we   = req_we[g_idx];
            bank_re   = !req_we[g_idx];
            g_len     = req_len[int'(g_idx)*2 +: 2];
            bank_adr  = req_adr[int'(g_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            bank_din  = req_wdata[int'(g_idx)*LW +: LW];
        end
    end

    assign bank_len = g_len;

    always_comb begin
        next_ptr = g_idx;
`ifdef CYCLIC_BANK_ARB_LOCK_EN
        // Parking the pointer just behind g keeps g first in line next cycle.
        if (req_lock[g_idx]) begin
            next_ptr = (g_idx == '0) ? ID_W'(NUM_REQ - 1) : g_idx - ID_W'(1);
        end
`endif
    end

    // Stage p1: remember who owns the read whose data arrives next cycle.
    always_ff @(posedge clk) begin
        if (bank_re) begin
            rd_id_p1 <= g_idx;
        end
    end

    // Stage p2: capture bank data into the response register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            rd_inflight <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr <= next_ptr;
            end
            rd_inflight <= bank_re;
            if (rd_inflight) begin
                rsp_valid <= 1'b1;
                rsp_id    <= rd_id_p1;
                rsp_data  <= bank_dout;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cyclic_bank_arb.sv
// Scoreboard bench for cyclic_bank_arb with a behavioural bank and arbiter model.
module tb_cyclic_bank_arb;

    localparam int N   = 4;
    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int IDW = 2;
    localparam int LW  = 4 * DW;
    localparam int DEPTH = 2048;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid, req_ready, req_we;
    logic [2*N-1:0]  req_len;
    logic [N*AW-1:0] req_adr;
    logic [N*LW-1:0] req_wdata;
`ifdef CYCLIC_BANK_ARB_LOCK_EN
    logic [N-1:0]    req_lock;
`endif
    logic            rsp_valid, rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [LW-1:0]   rsp_data;
    logic            bank_re, bank_we;
    logic [1:0]      bank_len;
    logic [AW-1:0]   bank_adr;
    logic [LW-1:0]   bank_din, bank_dout;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [LW-1:0]  data;
    } rsp_t;
    rsp_t expq[$];

    always #5 clk = ~clk;

    cyclic_bank_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_len(req_len), .req_adr(req_adr), .req_wdata(req_wdata),
`ifdef CYCLIC_BANK_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .bank_re(bank_re), .bank_we(bank_we), .bank_len(bank_len),
        .bank_adr(bank_adr), .bank_din(bank_din), .bank_dout(bank_dout)
    );

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bank: full-line read one cycle after re, writes len+1 words, addresses wrap.
    logic [DW-1:0] bank_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) bank_mem[i] <= '0;
            bank_dout <= '0;
        end else begin
            if (bank_we)
                for (int k = 0; k < 4; k++)
                    if (k <= int'(bank_len))
                        bank_mem[(int'(bank_adr) + k) % DEPTH] <= bank_din[k*DW +: DW];
            if (bank_re)
                for (int k = 0; k < 4; k++)
                    bank_dout[k*DW +: DW] <= bank_mem[(int'(bank_adr) + k) % DEPTH];
        end
    end

    // Reference model: grant order, response slot and memory contents.
    logic [DW-1:0] sh_mem [0:DEPTH-1];
    initial begin
        int m_rr;
        bit m_inf, m_rv, rd_ok;
        int g, a, ln;
        logic [N-1:0] exp_rdy;
        logic [LW-1:0] line, exp_din, act_din;
        rsp_t r;
        m_rr = N - 1; m_inf = 0; m_rv = 0;
        forever begin
            @(negedge clk); #2;
            if (!rstn) begin
                started = 1;
                m_rr = N - 1; m_inf = 0; m_rv = 0;
                expq.delete();
                for (int i = 0; i < DEPTH; i++) sh_mem[i] = '0;
                continue;
            end
            if (!started) continue;
            chk("rsp_valid", rsp_valid, m_rv);
            rd_ok = !m_inf && (!m_rv || rsp_ready);
            g = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (g < 0 && req_valid[c] && (req_we[c] || rd_ok)) g = c;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            if (g >= 0) begin
                a  = int'(req_adr[g*AW +: AW]);
                ln = int'(req_len[g*2 +: 2]);
                exp_din = req_we[g] ? req_wdata[g*LW +: LW] : '0;
                act_din = req_we[g] ? bank_din : '0;
                chk("bank_ctl", {bank_re, bank_we, bank_len, bank_adr, act_din},
                    {!req_we[g], req_we[g], ln[1:0], a[AW-1:0], exp_din});
                if (req_we[g]) begin
                    for (int k = 0; k <= ln; k++)
                        sh_mem[(a + k) % DEPTH] = req_wdata[g*LW + k*DW +: DW];
                end else begin
                    for (int k = 0; k < 4; k++) line[k*DW +: DW] = sh_mem[(a + k) % DEPTH];
                    r.id = IDW'(g);
                    r.data = line;
                    expq.push_back(r);
                end
            end else begin
                chk("bank_idle", {bank_re, bank_we, bank_len, bank_adr, bank_din}, '0);
            end
            if (m_inf) m_rv = 1;
            else if (rsp_ready) m_rv = 0;
            m_inf = (g >= 0) && !req_we[g];
            if (g >= 0) begin
                m_rr = g;
`ifdef CYCLIC_BANK_ARB_LOCK_EN
                if (req_lock[g]) m_rr = (g + N - 1) % N;
`endif
            end
        end
    end

    // Monitor: compare the presented response with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (started && rsp_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    chk("rsp_id", rsp_id, expq[0].id);
                    chk("rsp_data", rsp_data, expq[0].data);
                    if (rsp_ready) void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_valid = '0; req_we = '0; req_len = '0; req_adr = '0; req_wdata = '0;
`ifdef CYCLIC_BANK_ARB_LOCK_EN
        req_lock = '0;
`endif
    endtask

    task automatic set_req(int i, bit we, int len, int adr, logic [LW-1:0] wd);
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_len[i*2 +: 2] = len[1:0];
        req_adr[i*AW +: AW] = adr[AW-1:0];
        req_wdata[i*LW +: LW] = wd;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] l;
        for (int k = 0; k < 4; k++) l[k*DW +: DW] = $urandom;
        return l;
    endfunction

    initial begin
        logic [LW-1:0] l1013;
        int cnt [N];
        bit p0, p1, r2;
        int t0, t1;
        for (int k = 0; k < 4; k++) l1013[k*DW +: DW] = DW'(10 + k);
        rstn = 1'b0; rsp_ready = 1'b0;
        set_idle();
        tick(); tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_state", {rsp_valid, rsp_id, rsp_data, req_ready}, '0);

        // Write then read back the same line.
        tick(); set_req(0, 1, 3, 3, l1013);
        tick(); set_idle(); set_req(0, 0, 3, 3, '0);
        tick(); set_idle();
        @(negedge clk); chk("t1_latency", rsp_valid, 0);
        tick();
        @(negedge clk); chk("t1_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd0, l1013});

        // Response held: writes continue, the read waits for the slot.
        r2 = 0;
        for (int c = 0; c < 5; c++) begin
            tick(); set_idle(); set_req(1, 1, 0, 8, rnd_line()); set_req(2, 0, 1, 20, '0);
            @(negedge clk); r2 |= req_ready[2];
        end
        chk("t3_req2_blocked", r2, 0);
        chk("t3_rsp_hold", rsp_data, l1013);
        tick(); rsp_ready = 1'b1;
        @(negedge clk); chk("t3_req2_grant", req_ready, 4'b0100);
        tick(); set_idle();
        repeat (4) tick();

        // All requesters writing continuously.
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 12; c++) begin
            tick(); set_idle();
            for (int i = 0; i < N; i++) set_req(i, 1, $urandom_range(0, 3), $urandom_range(0, 63), rnd_line());
            @(negedge clk);
            for (int i = 0; i < N; i++) cnt[i] += int'(req_ready[i]);
        end
        for (int i = 0; i < N; i++) chk("t2_fair", cnt[i], 3);

        // Back-to-back reads from two requesters.
        p0 = 1; p1 = 1; t0 = -1; t1 = -1;
        for (int c = 0; c < 8; c++) begin
            tick(); set_idle();
            if (p0) set_req(0, 0, 3, 4, '0);
            if (p1) set_req(1, 0, 3, 5, '0);
            @(negedge clk);
            if (req_ready[0]) begin p0 = 0; t0 = c; end
            if (req_ready[1]) begin p1 = 0; t1 = c; end
        end
        chk("t4_both_granted", {p0, p1}, 2'b00);
        chk("t4_spacing", t1 - t0, 2);
        tick(); set_idle(); repeat (3) tick();

        // Reset right after a read grant drops the pending response.
        set_req(0, 0, 0, 7, '0);
        @(negedge clk); chk("t5_read_grant", req_ready, 4'b0001);
        tick(); set_idle(); rstn = 1'b0;
        tick(); rstn = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 40 + i, rnd_line());
        @(negedge clk);
        chk("t5_after_reset", {rsp_valid, req_ready}, {1'b0, 4'b0001});
        tick(); set_idle(); repeat (2) tick();

`ifdef CYCLIC_BANK_ARB_LOCK_EN
        rstn = 1'b0; tick(); rstn = 1'b1;
        tick(); set_req(2, 1, 0, 50, rnd_line()); req_lock[2] = 1'b1;
        @(negedge clk); chk("lock_g0", req_ready, 4'b0100);
        for (int c = 0; c < 2; c++) begin
            tick(); set_req(0, 1, 0, 51, rnd_line()); set_req(1, 1, 0, 52, rnd_line());
            set_req(2, 1, 0, 53, rnd_line()); req_lock[2] = 1'b1;
            @(negedge clk); chk("lock_hold", req_ready, 4'b0100);
        end
        tick(); req_valid[2] = 1'b0; req_lock = '0;
        @(negedge clk); chk("lock_release", req_ready, 4'b0001);
        tick(); set_idle();
`endif

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 1500; c++) begin
            tick(); set_idle();
            rstn = ($urandom_range(0, 199) != 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            if (rstn) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                                $urandom_range(0, 31) + (($urandom_range(0, 15) == 0) ? 2040 : 0), rnd_line());
`ifdef CYCLIC_BANK_ARB_LOCK_EN
                    req_lock[i] = ($urandom_range(0, 3) == 0);
`endif
                end
            end
        end
        tick(); set_idle(); rstn = 1'b1; rsp_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk); #3;
        chk("drain", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
